// File: rtl/ddr3_req_arbiter.sv
// Two-port arbiter in front of the ddr3_core request port; tags request IDs with the source port
// and steers responses back by resp_id[15]. Define DDR3_ARB_FIXED_PRIO_EN for strict p0 priority.
module ddr3_req_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  p0_addr_i,
    input  logic [15:0]  p0_wr_i,
    input  logic         p0_rd_i,
    input  logic [15:0]  p0_req_id_i,
    input  logic [127:0] p0_write_data_i,
    output logic         p0_accept_o,
    output logic         p0_ack_o,
    output logic         p0_error_o,
    output logic [127:0] p0_read_data_o,
    output logic [15:0]  p0_resp_id_o,
    input  logic [31:0]  p1_addr_i,
    input  logic [15:0]  p1_wr_i,
    input  logic         p1_rd_i,
    input  logic [15:0]  p1_req_id_i,
    input  logic [127:0] p1_write_data_i,
    output logic         p1_accept_o,
    output logic         p1_ack_o,
    output logic         p1_error_o,
    output logic [127:0] p1_read_data_o,
    output logic [15:0]  p1_resp_id_o,
    output logic [31:0]  out_addr_o,
    output logic [15:0]  out_wr_o,
    output logic         out_rd_o,
    output logic [15:0]  out_req_id_o,
    output logic [127:0] out_write_data_o,
    input  logic         out_accept_i,
    input  logic         out_ack_i,
    input  logic         out_error_i,
    input  logic [127:0] out_read_data_i,
    input  logic [15:0]  out_resp_id_i
);
    localparam logic [3:0] MAX_Q = 4'(MAX_OUTSTANDING);

    typedef enum logic {ST_ARB, ST_LOCK} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_lock;
    logic [3:0] r_out0;
    logic [3:0] r_out1;
    logic       w_req0;
    logic       w_req1;
    logic       w_winner;
    logic       w_grant;
    logic       w_gnt_req;
    logic       w_sel;
    logic       w_unused;

    assign w_req0 = ((|p0_wr_i) | p0_rd_i) & (r_out0 < MAX_Q);
    assign w_req1 = ((|p1_wr_i) | p1_rd_i) & (r_out1 < MAX_Q);

`ifdef DDR3_ARB_FIXED_PRIO_EN
    assign w_winner = ~w_req0 & w_req1;
`else
    logic r_rr;
    // On a tie the port that did not win last time goes next.
    assign w_winner = (w_req0 & w_req1) ? ~r_rr : (~w_req0 & w_req1);
`endif

    assign w_grant   = (r_state == ST_LOCK) ? r_lock : w_winner;
    assign w_gnt_req = w_grant ? w_req1 : w_req0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ARB:  if (w_gnt_req & ~out_accept_i) w_state_nxt = ST_LOCK;
            ST_LOCK: if (out_accept_i)              w_state_nxt = ST_ARB;
            default:                                w_state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_ARB;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock <= 1'b0;
`ifndef DDR3_ARB_FIXED_PRIO_EN
            r_rr   <= 1'b1;
`endif
        end else begin
            if (r_state == ST_ARB) r_lock <= w_grant;
`ifndef DDR3_ARB_FIXED_PRIO_EN
            if (out_accept_i & w_gnt_req) r_rr <= w_grant;
`endif
        end
    end

    assign out_addr_o       = w_gnt_req ? (w_grant ? p1_addr_i : p0_addr_i) : 32'd0;
    assign out_wr_o         = w_gnt_req ? (w_grant ? p1_wr_i : p0_wr_i) : 16'd0;
    assign out_rd_o         = w_gnt_req & (w_grant ? p1_rd_i : p0_rd_i);
    assign out_req_id_o     = w_gnt_req ? {w_grant, (w_grant ? p1_req_id_i[14:0] : p0_req_id_i[14:0])} : 16'd0;
    assign out_write_data_o = w_gnt_req ? (w_grant ? p1_write_data_i : p0_write_data_i) : 128'd0;

    assign p0_accept_o = out_accept_i & ~w_grant & w_req0;
    assign p1_accept_o = out_accept_i &  w_grant & w_req1;

    assign w_sel          = out_resp_id_i[15];
    assign p0_ack_o       = out_ack_i & ~w_sel;
    assign p1_ack_o       = out_ack_i &  w_sel;
    assign p0_error_o     = out_error_i;
    assign p1_error_o     = out_error_i;
    assign p0_read_data_o = out_read_data_i;
    assign p1_read_data_o = out_read_data_i;
    assign p0_resp_id_o   = {1'b0, out_resp_id_i[14:0]};
    assign p1_resp_id_o   = {1'b0, out_resp_id_i[14:0]};

    // Upstream keeps bit 15 of its IDs clear; the port tag replaces it.
    assign w_unused = p0_req_id_i[15] ^ p1_req_id_i[15];

    // An ack at zero is ignored so a stale response after reset cannot wrap the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out0 <= 4'd0;
            r_out1 <= 4'd0;
        end else begin
            if (p0_accept_o & ~(p0_ack_o & (r_out0 != 4'd0)))      r_out0 <= r_out0 + 4'd1;
            else if (~p0_accept_o & p0_ack_o & (r_out0 != 4'd0))   r_out0 <= r_out0 - 4'd1;
            if (p1_accept_o & ~(p1_ack_o & (r_out1 != 4'd0)))      r_out1 <= r_out1 + 4'd1;
            else if (~p1_accept_o & p1_ack_o & (r_out1 != 4'd0))   r_out1 <= r_out1 - 4'd1;
        end
    end
endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Directed bench for ddr3_req_arbiter: routing, round-robin, lock, outstanding limit, reset.
module tb_ddr3_req_arbiter;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p0_addr_i, p1_addr_i;
    logic [15:0]  p0_wr_i, p1_wr_i;
    logic         p0_rd_i, p1_rd_i;
    logic [15:0]  p0_req_id_i, p1_req_id_i;
    logic [127:0] p0_write_data_i, p1_write_data_i;
    logic         p0_accept_o, p0_ack_o, p0_error_o;
    logic         p1_accept_o, p1_ack_o, p1_error_o;
    logic [127:0] p0_read_data_o, p1_read_data_o;
    logic [15:0]  p0_resp_id_o, p1_resp_id_o;
    logic [31:0]  out_addr_o;
    logic [15:0]  out_wr_o;
    logic         out_rd_o;
    logic [15:0]  out_req_id_o;
    logic [127:0] out_write_data_o;
    logic         out_accept_i, out_ack_i, out_error_i;
    logic [127:0] out_read_data_i;
    logic [15:0]  out_resp_id_i;

    int n_chk = 0;
    int n_err = 0;

    ddr3_req_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_addr_i(p0_addr_i), .p0_wr_i(p0_wr_i), .p0_rd_i(p0_rd_i), .p0_req_id_i(p0_req_id_i),
        .p0_write_data_i(p0_write_data_i), .p0_accept_o(p0_accept_o), .p0_ack_o(p0_ack_o),
        .p0_error_o(p0_error_o), .p0_read_data_o(p0_read_data_o), .p0_resp_id_o(p0_resp_id_o),
        .p1_addr_i(p1_addr_i), .p1_wr_i(p1_wr_i), .p1_rd_i(p1_rd_i), .p1_req_id_i(p1_req_id_i),
        .p1_write_data_i(p1_write_data_i), .p1_accept_o(p1_accept_o), .p1_ack_o(p1_ack_o),
        .p1_error_o(p1_error_o), .p1_read_data_o(p1_read_data_o), .p1_resp_id_o(p1_resp_id_o),
        .out_addr_o(out_addr_o), .out_wr_o(out_wr_o), .out_rd_o(out_rd_o),
        .out_req_id_o(out_req_id_o), .out_write_data_o(out_write_data_o),
        .out_accept_i(out_accept_i), .out_ack_i(out_ack_i), .out_error_i(out_error_i),
        .out_read_data_i(out_read_data_i), .out_resp_id_i(out_resp_id_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        p0_addr_i = '0; p0_wr_i = '0; p0_rd_i = 1'b0; p0_req_id_i = '0; p0_write_data_i = '0;
        p1_addr_i = '0; p1_wr_i = '0; p1_rd_i = 1'b0; p1_req_id_i = '0; p1_write_data_i = '0;
        out_accept_i = 1'b0; out_ack_i = 1'b0; out_error_i = 1'b0;
        out_read_data_i = '0; out_resp_id_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        tick(); tick();
        settle();
        chk("rst_out_rd", out_rd_o, 0);
        chk("rst_out_id", out_req_id_o, 0);
        chk("rst_p0_acc", p0_accept_o, 0);
        chk("rst_p1_ack", p1_ack_o, 0);
        chk("rst_cnt0", dut.r_out0, 0);
        tick();
        rst_i = 1'b0;

        // Single p0 read and its ack
        p0_rd_i = 1'b1; p0_addr_i = 32'h100; p0_req_id_i = 16'h0003; out_accept_i = 1'b1;
        settle();
        chk("t1_addr", out_addr_o, 32'h100);
        chk("t1_id", out_req_id_o, 16'h0003);
        chk("t1_p0_acc", p0_accept_o, 1);
        chk("t1_p1_acc", p1_accept_o, 0);
        tick();
        p0_rd_i = 1'b0; out_accept_i = 1'b0;
        out_ack_i = 1'b1; out_resp_id_i = 16'h0003; out_read_data_i = 128'hCAFE_0000_1111_2222_3333_4444_5555_6666;
        settle();
        chk("t1_p0_ack", p0_ack_o, 1);
        chk("t1_p1_ack", p1_ack_o, 0);
        chk("t1_resp_id", p0_resp_id_o, 16'h0003);
        chk("t1_rdata", p1_read_data_o, 128'hCAFE_0000_1111_2222_3333_4444_5555_6666);
        tick();
        out_ack_i = 1'b0;
        settle();
        chk("t1_cnt0", dut.r_out0, 0);

`ifndef DDR3_ARB_FIXED_PRIO_EN
        // Both requesting, core always accepts: p0,p1,p0,p1
        do_reset();
        p0_rd_i = 1'b1; p0_req_id_i = 16'h0011;
        p1_rd_i = 1'b1; p1_req_id_i = 16'h0022;
        out_accept_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t2_rr_id", out_req_id_o, (i % 2 == 0) ? 16'h0011 : 16'h8022);
            chk("t2_rr_acc1", p1_accept_o, (i % 2 == 1) ? 1 : 0);
            tick();
        end
`else
        // Fixed priority: p1 starves while p0 keeps requesting
        do_reset();
        p0_rd_i = 1'b1; p0_req_id_i = 16'h0011;
        p1_rd_i = 1'b1; p1_req_id_i = 16'h0022;
        out_accept_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("fp_p1_acc", p1_accept_o, 0);
            chk("fp_p0_acc", p0_accept_o, 1);
            out_ack_i = 1'b1; out_resp_id_i = 16'h0011;
            tick();
        end
        out_ack_i = 1'b0;
`endif

        // Lock: p1 presented, accept low, p0 arrives later
        do_reset();
        p1_rd_i = 1'b1; p1_addr_i = 32'h200; p1_req_id_i = 16'h0005;
        settle();
        chk("t3_id0", out_req_id_o, 16'h8005);
        tick();
        p0_rd_i = 1'b1; p0_addr_i = 32'h300; p0_req_id_i = 16'h0007;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t3_lock_id", out_req_id_o, 16'h8005);
            chk("t3_lock_p0acc", p0_accept_o, 0);
            tick();
        end
        out_accept_i = 1'b1;
        settle();
        chk("t3_p1_acc", p1_accept_o, 1);
        chk("t3_addr", out_addr_o, 32'h200);
        tick();
        p1_rd_i = 1'b0;
        settle();
        chk("t3_p0_id", out_req_id_o, 16'h0007);
        chk("t3_p0_acc", p0_accept_o, 1);
        tick();

        // Outstanding limit on p1
        do_reset();
        p1_rd_i = 1'b1; p1_req_id_i = 16'h0009; out_accept_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t4_acc", p1_accept_o, 1);
            tick();
        end
        settle();
        chk("t4_full_acc", p1_accept_o, 0);
        chk("t4_full_rd", out_rd_o, 0);
        chk("t4_cnt", dut.r_out1, 4);
        tick();
        out_ack_i = 1'b1; out_resp_id_i = 16'h8009;
        settle();
        chk("t4_p1_ack", p1_ack_o, 1);
        chk("t4_p0_ack", p0_ack_o, 0);
        chk("t4_resp_id", p1_resp_id_o, 16'h0009);
        chk("t4_ack_acc", p1_accept_o, 0);
        tick();
        out_ack_i = 1'b0;
        settle();
        chk("t4_reopen_acc", p1_accept_o, 1);
        tick();

        // Same-cycle accept and ack at count 2
        do_reset();
        p0_rd_i = 1'b1; p0_req_id_i = 16'h0001; out_accept_i = 1'b1;
        tick(); tick();
        settle();
        chk("t5_cnt_pre", dut.r_out0, 2);
        out_ack_i = 1'b1; out_resp_id_i = 16'h0001;
        settle();
        chk("t5_both_acc", p0_accept_o, 1);
        chk("t5_both_ack", p0_ack_o, 1);
        tick();
        settle();
        chk("t5_cnt_post", dut.r_out0, 2);

        // Ack at count zero must not underflow
        do_reset();
        out_ack_i = 1'b1; out_resp_id_i = 16'h0004;
        tick();
        out_ack_i = 1'b0;
        settle();
        chk("t6_no_uflow", dut.r_out0, 0);

        // Reset in the middle of a lock
        p1_rd_i = 1'b1; p1_req_id_i = 16'h0002; out_accept_i = 1'b0;
        tick();
        settle();
        chk("t7_locked", dut.r_state, 1);
        idle_inputs();
        rst_i = 1'b1;
        tick();
        settle();
        chk("t7_state_arb", dut.r_state, 0);
        chk("t7_cnt1", dut.r_out1, 0);
        chk("t7_out_rd", out_rd_o, 0);
        tick();
        rst_i = 1'b0;
        out_ack_i = 1'b1; out_resp_id_i = 16'h8002;
        settle();
        chk("t7_late_ack", p1_ack_o, 1);
        tick();
        out_ack_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
